mat_fetch_ctrl: RTL
===================

# mat_fetch_ctrl

Upstream fetch stage of the matrix-vector multiply datapath. On a start pulse it issues nine Avalon-MM reads to the 64-bit on-chip memory: word 0 is vector B and words 1..8 are matrix rows A0..A7. Each returned word is unpacked into eight bytes, and those bytes are pushed one per cycle into the matching input FIFO of the MAC array. When the last byte is written the block raises `done`, and the compute controller moves from FETCH to COMPUTE.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width pushed into each FIFO.
- `NUM_ROWS`, 8: matrix rows (A FIFOs); total FIFOs = NUM_ROWS+1.
- `BYTES_PER_WORD`, 8: bytes per memory word (readdata = 64 bits).
- `ADDR_WIDTH`, 32: Avalon address width.

Ports:
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle start request; ignored unless in IDLE or DONE.
- `address`, out, ADDR_WIDTH: word address of the current read.
- `read`, out, 1: Avalon read request.
- `readdata`, in, 64: read data.
- `readdatavalid`, in, 1: readdata valid this cycle.
- `waitrequest`, in, 1: memory stalls the request.
- `fifo_wr_en`, out, NUM_ROWS+1: one-hot push; bit 0 = B FIFO, bit r+1 = A row r.
- `fifo_wr_data`, out, DATA_WIDTH: byte being pushed.
- `fifo_full`, in, NUM_ROWS+1: per-FIFO full flag.
- `busy`, out, 1: high from accepted start until done.
- `done`, out, 1: high in DONE, held until the next accepted start.

## Operation
States:
- **IDLE**
  - Outputs at reset: read=0, address=0, fifo_wr_en=0, fifo_wr_data=0, busy=0, done=0.
  - Reset also sets word counter=0 and byte counter=0.
  - start → REQ.
- **REQ**
  - Drive read=1 and address=word counter.
  - Hold read and address stable while waitrequest=1.
  - Accept on the first cycle with waitrequest=0 → WAIT; read deasserts the next cycle.
- **WAIT**
  - Wait for readdatavalid=1, then load readdata into the unpack register → UNPACK.
  - readdatavalid seen in any other state is ignored.
- **UNPACK**
  - Each cycle, present the current byte on fifo_wr_data, MSB first: readdata[63:56] first, readdata[7:0] last.
  - If fifo_full[target]=0: assert fifo_wr_en[target] (target = word counter), shift the register, and increment the byte counter.
  - If fifo_full[target]=1: push nothing and hold the byte (stall).
  - After the 8th push:
    - if word counter = NUM_ROWS → DONE;
    - else increment the word counter → REQ.
- **DONE**
  - done=1, busy=0.
  - start → clear both counters and done, go to REQ.

Rules:
- Exactly one bit of fifo_wr_en is high at a time, never more.
- fifo_wr_en is never high when the targeted fifo_full is high.
- `start` arriving while busy has no effect.
- rst_n low at any point, mid-read or mid-unpack, returns the block to IDLE immediately. Reset values apply asynchronously, and in-flight read data is discarded.
- The address counter covers 0..NUM_ROWS; it never wraps within one run.

## Timing
- start is registered; REQ (read=1) begins the cycle after start is sampled.
- Best case per word: 1 REQ cycle, then WAIT (≥1 cycle), then 8 UNPACK cycles.
- With zero waitrequest and readdatavalid 1 cycle after accept, each word takes 10 cycles and the full run takes 90 cycles from first read to done.
- The fifo_wr_en and fifo_wr_data outputs are registered, so a push happens on the clock edge after the UNPACK cycle that issues it.
- done rises on the cycle after the final push is issued.
- busy falls in that same cycle.

## Configuration
`MAT_FETCH_PERF_EN`
- Defined:
  - Adds output `perf_cycles` [15:0], counting cycles while busy=1.
  - The count saturates at 16'hFFFF, clears on an accepted start, and holds its value in DONE.
  - Adds output `perf_stalls` [15:0], counting UNPACK cycles lost to fifo_full, with the same saturate and clear rules.
- Undefined: neither port exists and no counter logic is synthesised. All other behaviour is identical.

## Structure
Package `mat_fetch_pkg` holds:
- the state enum `fetch_state_t` (IDLE, REQ, WAIT, UNPACK, DONE);
- localparams `NUM_FIFOS = NUM_ROWS+1` and `WORD_WIDTH = 64`.

One sub-module, `word_unpacker`:
- a 64-bit load/shift register with a byte counter;
- outputs the current byte and a `last` flag;
- shifts on an `advance` input.

## Test plan
- **Basic run:** memory word k = {8{8'h(k+1)}}, no stalls, start pulse. Required response:
  - read addresses 0..8 appear in order;
  - B FIFO receives eight 8'h01;
  - row 7 FIFO receives eight 8'h09;
  - done rises exactly 90 cycles after the first read.
- **Byte order:** word 0 = 64'h0102030405060708. B FIFO receives 01,02,…,08 in that order.
- **waitrequest stall:** waitrequest held high for 5 cycles on address 3. read and address stay at 3 throughout and advance only after acceptance; total run is 95 cycles.
- **FIFO backpressure:** fifo_full[2] high for 4 cycles mid-unpack. No push while it is high, no byte is lost or duplicated, and row 1 still holds exactly 8 bytes.
- **Start ignored and reset mid-op:**
  - a second start during word 4 has no effect;
  - rst_n pulsed low during word 6 returns all outputs to reset values within the same cycle;
  - a new start then replays from address 0.
- **Perf counters:** with `MAT_FETCH_PERF_EN` defined, the FIFO backpressure scenario ends with perf_stalls=4 and perf_cycles=94.

Source files
------------

// File: rtl/mat_fetch_pkg.sv
// Shared types and constants for the matrix fetch controller.
// Optional feature macro: MAT_FETCH_PERF_EN (adds perf counters in mat_fetch_ctrl).
package mat_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    UNPACK,
    DONE
  } fetch_state_t;

  localparam int DEF_NUM_ROWS = 8;
  localparam int NUM_FIFOS    = DEF_NUM_ROWS + 1;
  localparam int WORD_WIDTH   = 64;

endpackage

// File: rtl/mat_fetch_ctrl_word_unpacker.sv
// Load/shift register that hands out one memory word a byte at a time, MSB first.
module word_unpacker
  import mat_fetch_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  last
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Load restarts the byte count; each advance drops the top byte.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = data_in;
      cnt_d   = '0;
    end else if (advance) begin
      shreg_d = shreg_q << DATA_WIDTH;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Register and byte counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_out = shreg_q[WORD_WIDTH-1 -: DATA_WIDTH];
  assign last     = (cnt_q == CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mat_fetch_ctrl.sv
// Fetch stage: reads vector B (word 0) and rows A0..A7 (words 1..8) over
// Avalon-MM and streams their bytes, MSB first, into the per-row input FIFOs.
// Optional feature macro: MAT_FETCH_PERF_EN adds perf_cycles / perf_stalls.
module mat_fetch_ctrl
  import mat_fetch_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_ROWS       = DEF_NUM_ROWS,
  parameter int BYTES_PER_WORD = 8,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  input  logic [WORD_WIDTH-1:0] readdata,
  input  logic                  readdatavalid,
  input  logic                  waitrequest,
  output logic [NUM_ROWS:0]     fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic [NUM_ROWS:0]     fifo_full,
  output logic                  busy,
  output logic                  done
`ifdef MAT_FETCH_PERF_EN
  ,
  output logic [15:0]           perf_cycles,
  output logic [15:0]           perf_stalls
`endif
);

  localparam int WCW = $clog2(NUM_ROWS + 1);

  fetch_state_t          state_q, state_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  read_q, read_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [NUM_ROWS:0]     wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  start_ok, tgt_full, unp_load, unp_adv, unp_last;
  logic [DATA_WIDTH-1:0] unp_byte;

  // Word counter doubles as the FIFO index: word 0 -> B, word r+1 -> row r.
  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign tgt_full = fifo_full[wcnt_q];
  assign unp_load = (state_q == WAIT) && readdatavalid;
  assign unp_adv  = (state_q == UNPACK) && !tgt_full;

  word_unpacker #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_unpack (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (unp_load),
    .advance (unp_adv),
    .data_in (readdata),
    .byte_out(unp_byte),
    .last    (unp_last)
  );

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    read_d    = read_q;
    address_d = address_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = REQ;
          wcnt_d    = '0;
          read_d    = 1'b1;
          address_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      REQ: begin
        // read/address simply hold while the slave stalls
        if (!waitrequest) begin
          state_d = WAIT;
          read_d  = 1'b0;
        end
      end
      WAIT: begin
        if (readdatavalid) state_d = UNPACK;
      end
      UNPACK: begin
        if (!tgt_full) begin
          wr_en_d[wcnt_q] = 1'b1;
          wr_data_d       = unp_byte;
          if (unp_last) begin
            if (wcnt_q == WCW'(NUM_ROWS)) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              wcnt_d    = wcnt_q + 1'b1;
              state_d   = REQ;
              read_d    = 1'b1;
              address_d = ADDR_WIDTH'(wcnt_d);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      read_q    <= 1'b0;
      address_q <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      read_q    <= read_d;
      address_q <= address_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign read         = read_q;
  assign address      = address_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef MAT_FETCH_PERF_EN
  logic [15:0] pcyc_q, pcyc_d, pstl_q, pstl_d;

  // Saturating busy-cycle and FIFO-stall counters, cleared by an accepted start.
  always_comb begin
    pcyc_d = pcyc_q;
    pstl_d = pstl_q;
    if (start_ok) begin
      pcyc_d = '0;
      pstl_d = '0;
    end else begin
      if (busy_q && pcyc_q != 16'hFFFF) pcyc_d = pcyc_q + 16'd1;
      if (state_q == UNPACK && tgt_full && pstl_q != 16'hFFFF) pstl_d = pstl_q + 16'd1;
    end
  end

  // Perf counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcyc_q <= '0;
      pstl_q <= '0;
    end else begin
      pcyc_q <= pcyc_d;
      pstl_q <= pstl_d;
    end
  end

  assign perf_cycles = pcyc_q;
  assign perf_stalls = pstl_q;
`endif

endmodule
